vga_timing_gen: RTL and testbench

// Parametrised VGA timing generator; successor to the fixed 640x480 sync block in VGA_controller.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_pixel_tick_div.sv | 40 ++++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the timing generator and pixel pipeline.
// Each mode bundles one complete set of porch/sync widths with the counter width it needs.
package vga_timing_pkg;

  typedef struct packed {
    int clk_div;
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    int cnt_w;
  } vga_timing_t;

  // 640x480@60 from a 100 MHz system clock (25 MHz pixel rate).
  localparam vga_timing_t VGA_640X480_60 = '{
    clk_div:  4,
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    cnt_w:    10
  };

  // 800x600@60 assumes the system clock already runs at the 40 MHz pixel rate.
  localparam vga_timing_t SVGA_800X600_60 = '{
    clk_div:  1,
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    cnt_w:    11
  };

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pixel_tick_div.sv
// Divides the system clock into a registered one-clk pixel strobe every CLK_DIV clocks.
// With en low the phase counter freezes, so the strobe cadence resumes where it stopped.
module vga_pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_p_tick;
  logic             w_div_wrap;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_pixel_tick_div: CLK_DIV must be at least 1");
  end

  assign w_div_wrap = (r_div_cnt == DIV_LAST);

  // With CLK_DIV=1 the counter sits at 0, which is also DIV_LAST, so the strobe stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_p_tick  <= 1'b0;
    end else if (en) begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      r_p_tick  <= w_div_wrap;
    end else begin
      r_p_tick  <= 1'b0;
    end
  end

  assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, h/v counters and registered sync/blank decode.
// Decode is taken from the next-state counts so every output lines up with the counts it describes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_640X480_60.clk_div,
  parameter int H_ACTIVE = VGA_640X480_60.h_active,
  parameter int H_FP     = VGA_640X480_60.h_fp,
  parameter int H_SYNC   = VGA_640X480_60.h_sync,
  parameter int H_BP     = VGA_640X480_60.h_bp,
  parameter int V_ACTIVE = VGA_640X480_60.v_active,
  parameter int V_FP     = VGA_640X480_60.v_fp,
  parameter int V_SYNC   = VGA_640X480_60.v_sync,
  parameter int V_BP     = VGA_640X480_60.v_bp,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = VGA_640X480_60.cnt_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             h_scan,
  output logic             v_scan,
  output logic             h_video_on,
  output logic             v_video_on,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

  logic             w_tick;
  logic             w_adv;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;

  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_h_scan;
  logic             r_v_scan;
  logic             r_h_video_on;
  logic             r_v_video_on;
  logic             r_video_on;
  logic             r_line_start;
  logic             r_frame_start;

  vga_pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .p_tick (w_tick)
  );

  assign w_adv    = en & w_tick;
  assign w_h_wrap = (r_h_count == H_LAST);
  assign w_v_wrap = w_h_wrap & (r_v_count == V_LAST);
  assign w_h_next = w_h_wrap ? '0 : r_h_count + 1'b1;
  assign w_v_next = w_v_wrap ? '0 : (w_h_wrap ? r_v_count + 1'b1 : r_v_count);

  // Reset values describe position (0,0): visible area, syncs inactive, no strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_h_scan      <= ~SYNC_POL;
      r_v_scan      <= ~SYNC_POL;
      r_h_video_on  <= 1'b1;
      r_v_video_on  <= 1'b1;
      r_video_on    <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_adv) begin
        r_h_count     <= w_h_next;
        r_v_count     <= w_v_next;
        r_h_scan      <= in_window(w_h_next, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        r_v_scan      <= in_window(w_v_next, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        r_h_video_on  <= in_window(w_h_next, 0, H_ACTIVE);
        r_v_video_on  <= in_window(w_v_next, 0, V_ACTIVE);
        r_video_on    <= in_window(w_h_next, 0, H_ACTIVE) & in_window(w_v_next, 0, V_ACTIVE);
        r_line_start  <= w_h_wrap;
        r_frame_start <= w_v_wrap;
      end
    end
  end

  assign p_tick      = w_tick;
  assign h_count     = r_h_count;
  assign v_count     = r_v_count;
  assign h_scan      = r_h_scan;
  assign v_scan      = r_v_scan;
  assign h_video_on  = r_h_video_on;
  assign v_video_on  = r_v_video_on;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a CLK_DIV=1, active-high-sync, short-frame instance.
module tb_vga_timing_gen;

  localparam int CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic a_tick, a_hs, a_vs, a_hvo, a_vvo, a_vo, a_ls, a_fs;
  logic b_tick, b_hs, b_vs, b_hvo, b_vvo, b_vo, b_ls, b_fs;
  logic [CW-1:0] a_h, a_v, b_h, b_v;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .p_tick(a_tick),
    .h_count(a_h), .v_count(a_v), .h_scan(a_hs), .v_scan(a_vs),
    .h_video_on(a_hvo), .v_video_on(a_vvo), .video_on(a_vo),
    .line_start(a_ls), .frame_start(a_fs)
  );

  // Default horizontal timing, 8-line frame: visible 0..3, sync 5..6.
  vga_timing_gen #(
    .CLK_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .p_tick(b_tick),
    .h_count(b_h), .v_count(b_v), .h_scan(b_hs), .v_scan(b_vs),
    .h_video_on(b_hvo), .v_video_on(b_vvo), .video_on(b_vo),
    .line_start(b_ls), .frame_start(b_fs)
  );

  typedef struct {
    int   n;      // clock edges since reset release
    logic en;
    logic tick;
    int   h;
  } vec_t;

  vec_t tbl[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   na;
  int   nb;

  task automatic chkc(input string name, input logic [CW-1:0] act, input int exp);
    n_cmp++;
    if (act !== CW'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chkb({tag, ".p_tick"}, a_tick, 1'b0);
    chkc({tag, ".h_count"}, a_h, 0);
    chkc({tag, ".v_count"}, a_v, 0);
    chkb({tag, ".h_scan"}, a_hs, 1'b1);
    chkb({tag, ".v_scan"}, a_vs, 1'b1);
    chkb({tag, ".h_video_on"}, a_hvo, 1'b1);
    chkb({tag, ".v_video_on"}, a_vvo, 1'b1);
    chkb({tag, ".video_on"}, a_vo, 1'b1);
    chkb({tag, ".line_start"}, a_ls, 1'b0);
    chkb({tag, ".frame_start"}, a_fs, 1'b0);
  endtask

  task automatic chk_reset_b(input string tag);
    chkb({tag, ".p_tick"}, b_tick, 1'b0);
    chkc({tag, ".h_count"}, b_h, 0);
    chkc({tag, ".v_count"}, b_v, 0);
    chkb({tag, ".h_scan"}, b_hs, 1'b0);
    chkb({tag, ".v_scan"}, b_vs, 1'b0);
    chkb({tag, ".video_on"}, b_vo, 1'b1);
    chkb({tag, ".line_start"}, b_ls, 1'b0);
    chkb({tag, ".frame_start"}, b_fs, 1'b0);
  endtask

  task automatic apply_table_a();
    na = 0;
    foreach (tbl[i]) begin
      while (na < tbl[i].n) begin
        en_a = tbl[i].en;
        step();
        na++;
      end
      chkb("tbl.p_tick", a_tick, tbl[i].tick);
      chkc("tbl.h_count", a_h, tbl[i].h);
      chkc("tbl.v_count", a_v, 0);
      chkb("tbl.line_start", a_ls, 1'b0);
    end
  endtask

  // Default instance, en held high: pixel index advances on edges 5, 9, 13, ...
  task automatic check_a_sweep(input int n);
    int p;
    int h;
    int v;
    p = (n - 1) / 4;
    h = p % 800;
    v = (p / 800) % 525;
    chkb("a.p_tick", a_tick, (n % 4) == 0);
    chkc("a.h_count", a_h, h);
    chkc("a.v_count", a_v, v);
    chkb("a.h_scan", a_hs, !(h >= 656 && h < 752));
    chkb("a.v_scan", a_vs, !(v >= 490 && v < 492));
    chkb("a.h_video_on", a_hvo, h < 640);
    chkb("a.v_video_on", a_vvo, v < 480);
    chkb("a.video_on", a_vo, (h < 640) && (v < 480));
    chkb("a.line_start", a_ls, ((n % 4) == 1) && (n >= 5) && (h == 0));
    chkb("a.frame_start", a_fs, ((n % 4) == 1) && (n >= 5) && (h == 0) && (v == 0));
  endtask

  // CLK_DIV=1 instance: tick high from edge 1, counts advance from edge 2.
  task automatic check_b_sweep(input int n);
    int p;
    int h;
    int v;
    p = n - 1;
    h = p % 800;
    v = (p / 800) % 8;
    chkb("b.p_tick", b_tick, 1'b1);
    chkc("b.h_count", b_h, h);
    chkc("b.v_count", b_v, v);
    chkb("b.h_scan", b_hs, (h >= 656) && (h < 752));
    chkb("b.v_scan", b_vs, (v >= 5) && (v < 7));
    chkb("b.h_video_on", b_hvo, h < 640);
    chkb("b.v_video_on", b_vvo, v < 4);
    chkb("b.video_on", b_vo, (h < 640) && (v < 4));
    chkb("b.line_start", b_ls, (n >= 2) && (h == 0));
    chkb("b.frame_start", b_fs, (n >= 2) && (h == 0) && (v == 0));
  endtask

  initial begin
    int guard;
    tbl[0] = '{n: 1, en: 1'b1, tick: 1'b0, h: 0};
    tbl[1] = '{n: 3, en: 1'b1, tick: 1'b0, h: 0};
    tbl[2] = '{n: 4, en: 1'b1, tick: 1'b1, h: 0};
    tbl[3] = '{n: 5, en: 1'b1, tick: 1'b0, h: 1};
    tbl[4] = '{n: 8, en: 1'b1, tick: 1'b1, h: 1};
    tbl[5] = '{n: 9, en: 1'b1, tick: 1'b0, h: 2};

    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    repeat (3) step();
    chk_reset_a("a.rst");
    chk_reset_b("b.rst");

    // Startup cadence, then one full line plus the wrap into line 1.
    rst_a = 1'b1;
    en_a  = 1'b1;
    apply_table_a();
    while (na < 4401) begin
      step();
      na++;
      check_a_sweep(na);
    end

    // Freeze at h_count=300 with the divider one clk into its phase.
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chkb("hold.p_tick", a_tick, 1'b0);
      chkc("hold.h_count", a_h, 300);
      chkc("hold.v_count", a_v, 1);
      chkb("hold.h_scan", a_hs, 1'b1);
      chkb("hold.v_scan", a_vs, 1'b1);
      chkb("hold.h_video_on", a_hvo, 1'b1);
      chkb("hold.line_start", a_ls, 1'b0);
      chkb("hold.frame_start", a_fs, 1'b0);
    end
    en_a = 1'b1;
    step(); chkb("resume1.p_tick", a_tick, 1'b0); chkc("resume1.h_count", a_h, 300);
    step(); chkb("resume2.p_tick", a_tick, 1'b0); chkc("resume2.h_count", a_h, 300);
    step(); chkb("resume3.p_tick", a_tick, 1'b1); chkc("resume3.h_count", a_h, 300);
    step(); chkb("resume4.p_tick", a_tick, 1'b0); chkc("resume4.h_count", a_h, 301);

    // Move into the sync region, then reset asynchronously mid-line.
    guard = 0;
    while (a_h !== CW'(700) && guard < 2000) begin
      step();
      guard++;
    end
    chkc("seek.h_count", a_h, 700);
    chkc("seek.v_count", a_v, 1);
    chkb("seek.h_scan", a_hs, 1'b0);
    chkb("seek.h_video_on", a_hvo, 1'b0);
    chkb("seek.video_on", a_vo, 1'b0);
    rst_a = 1'b0;
    #1;
    chk_reset_a("a.midrst");
    step();
    rst_a = 1'b1;
    apply_table_a();
    en_a = 1'b0;

    // Fast instance: more than one full frame, then reset inside vertical sync.
    rst_b = 1'b1;
    en_b  = 1'b1;
    nb    = 0;
    while (nb < 10500) begin
      step();
      nb++;
      check_b_sweep(nb);
    end
    chkb("b.pre_rst.v_scan", b_vs, 1'b1);
    rst_b = 1'b0;
    #1;
    chk_reset_b("b.midrst");
    step();
    rst_b = 1'b1;
    step();
    chkb("b.rel1.p_tick", b_tick, 1'b1);
    chkc("b.rel1.h_count", b_h, 0);
    step();
    chkc("b.rel2.h_count", b_h, 1);
    chkc("b.rel2.v_count", b_v, 0);
    chkb("b.rel2.line_start", b_ls, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
